pci_mem_target_n: RTL and testbench
===================================

PCI_MEM_TARGET_N -- requirements
Module: pci_mem_target_n

Interface
REQ-001 Parameter DW, 32, data width; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, 256, memory depth in DW-wide words; SHALL be a power of 2 and at least 2.
REQ-003 Parameter BAR_IDX, 2, index of the base_hit bit that claims a transaction.
REQ-004 Parameter WAIT_STATES, 0, target wait cycles per data phase; legal range 0..7.
REQ-005 Parameter INIT_WORD, 32'h0123_4567, memory reset seed.
REQ-006 CLK  in  1  clock; all state changes on its rising edge.
REQ-007 reset  in  1  reset; asynchronous, active-high.
REQ-008 s_wrdn  in  1  1 = write, 0 = read; sampled with addr_vld.
REQ-009 pci_cmd  in  16  one-hot command; 16'h0040 = memory read, 16'h0080 = memory write.
REQ-010 addr  in  32  byte address; sampled with addr_vld.
REQ-011 base_hit  in  8  BAR hit vector.
REQ-012 addr_vld  in  1  address phase strobe.
REQ-013 s_data  in  1  data phases in progress.
REQ-014 s_data_vld  in  1  one data beat completes this cycle.
REQ-015 s_cbe  in  DW/8  active-low byte enables for the current beat.
REQ-016 adio_out  in  DW  write data.
REQ-017 adio_in  out  DW  read data, tri-stated when not driving.
REQ-018 s_ready  out  1  target ready (registered).
REQ-019 s_term  out  1  target disconnect (registered).
REQ-020 s_abort  out  1  target abort (registered).
REQ-021 xfer_cnt  out  16  completed data beats since reset; saturates at 16'hFFFF.

Function
REQ-022 FSM states: IDLE, ACTIVE, TERM, ABORT. Reset state is IDLE.
REQ-023 IDLE -> claim: addr_vld & base_hit[BAR_IDX] in cycle N latches ptr = addr[log2(DEPTH)+1:2] and dir = s_wrdn.
REQ-024 Legality check: a read with pci_cmd == 16'h0040 or a write with pci_cmd == 16'h0080 goes to ACTIVE at N+1. Any other command, or a command that mismatches s_wrdn, goes to ABORT at N+1.
REQ-025 Wait counter: loads WAIT_STATES on entry to ACTIVE and after every accepted beat. s_ready = 1 only in ACTIVE with counter == 0. With WAIT_STATES = 0, s_ready is 1 from cycle N+1.
REQ-026 Accepted beat: s_data_vld & s_ready in ACTIVE. s_data_vld while s_ready = 0 is ignored; ptr, memory and xfer_cnt are unchanged.
REQ-027 Write beat: for each lane i where s_cbe[i] = 0, mem[ptr] byte i <= adio_out byte i. Lanes where s_cbe[i] = 1 are unchanged.
REQ-028 Read: while in ACTIVE with dir = read and s_data = 1, adio_in = mem[ptr] combinationally; otherwise adio_in = high-Z.
REQ-029 Each accepted beat increments ptr by 1 and increments xfer_cnt unless xfer_cnt = 16'hFFFF.
REQ-030 Boundary: an accepted beat at ptr = DEPTH-1 moves the FSM to TERM the next cycle. ptr does not wrap.
REQ-031 TERM: s_term = 1, s_ready = 0, adio_in high-Z, no memory writes.
REQ-032 ABORT: s_abort = 1, s_ready = 0, adio_in high-Z, no memory writes, xfer_cnt unchanged.
REQ-033 ACTIVE, TERM or ABORT with s_data = 0 and addr_vld = 0 returns to IDLE the next cycle; all strobes deassert at that edge.
REQ-034 A base_hit or addr_vld arriving while not in IDLE is ignored.
REQ-035 In IDLE: s_ready = s_term = s_abort = 0 and adio_in is high-Z.

Reset
REQ-036 On reset: FSM = IDLE; s_ready = s_term = s_abort = 0; xfer_cnt = 0; ptr = 0; wait counter = 0; adio_in high-Z.
REQ-037 On reset: mem[i] = INIT_WORD + i (truncated to DW bits) for every i.
REQ-038 reset asserted mid-burst aborts the transaction immediately; no further writes occur. After release the block accepts a new claim on the first clock edge.

Verification
REQ-039 After reset, read claim at addr 0x0, pci_cmd 0x0040, WAIT_STATES = 0, 3 beats -> adio_in = 0x01234567, 0x01234568, 0x01234569; s_ready = 1 from N+1; xfer_cnt = 3.
REQ-040 Write claim at addr 0x8, s_cbe = 4'b1010, adio_out = 0xAABBCCDD, then read back addr 0x8 -> 0x01BB45DD.
REQ-041 WAIT_STATES = 2, 2-beat read -> s_ready pattern after claim: 0,0,1, then 0,0,1 after the first beat; s_data_vld in the low cycles is ignored.
REQ-042 Write claim at addr (DEPTH-1)*4 with 2 beats offered -> first beat written; s_term = 1 the next cycle; second beat ignored; return to IDLE one cycle after s_data = 0.
REQ-043 Claim with pci_cmd 0x0040 and s_wrdn = 1, or pci_cmd 0x0004 -> s_abort = 1 at N+1; memory and xfer_cnt unchanged.
REQ-044 Assert reset in the middle of a 4-beat write burst -> outputs drop to 0 asynchronously; memory reinitialises to INIT_WORD + i; a subsequent claim works normally.

Source files
------------

// File: rtl/pci_mem_target_n.sv
// PCI memory target: claims BAR hits, runs read/write data phases against an
// internal word memory with optional wait states, disconnect at the top word and abort on bad commands.
module pci_mem_target_n #(
    parameter int          DW          = 32,
    parameter int          DEPTH       = 256,
    parameter int          BAR_IDX     = 2,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] INIT_WORD   = 32'h0123_4567
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              s_wrdn,
    input  logic [15:0]       pci_cmd,
    input  logic [31:0]       addr,
    input  logic [7:0]        base_hit,
    input  logic              addr_vld,
    input  logic              s_data,
    input  logic              s_data_vld,
    input  logic [DW/8-1:0]   s_cbe,
    input  logic [DW-1:0]     adio_out,
    output logic [DW-1:0]     adio_in,
    output logic              s_ready,
    output logic              s_term,
    output logic              s_abort,
    output logic [15:0]       xfer_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DW / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_TERM   = 2'd2;
    localparam logic [1:0] ST_ABORT  = 2'd3;

    localparam logic [15:0]   CMD_MEM_RD = 16'h0040;
    localparam logic [15:0]   CMD_MEM_WR = 16'h0080;
    localparam logic [2:0]    WAIT_LOAD  = 3'(WAIT_STATES);
    localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH - 1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_ptr;
    logic          r_dir;
    logic [2:0]    r_wait;
    logic          r_ready;
    logic          r_term;
    logic          r_abort;
    logic [15:0]   r_xfer_cnt;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_claim;
    logic          w_legal;
    logic          w_beat;
    logic          w_exit;
    logic          w_drive;
    logic [1:0]    w_state_nx;
    logic [2:0]    w_wait_nx;
    logic          w_unused;

    assign w_unused = ^{addr[31:AW+2], addr[1:0], base_hit};

    // NOTE: every signal assigned in this block gets a default first, so no path leaves it holding a value (no latch).
    always_comb begin
        w_claim    = addr_vld & base_hit[BAR_IDX];
        w_legal    = (!s_wrdn && pci_cmd == CMD_MEM_RD) || (s_wrdn && pci_cmd == CMD_MEM_WR);
        w_beat     = (r_state == ST_ACTIVE) && s_data_vld && r_ready;
        w_exit     = !s_data && !addr_vld;
        w_state_nx = r_state;
        w_wait_nx  = r_wait;
        case (r_state)
            ST_IDLE: begin
                if (w_claim) begin
                    w_state_nx = w_legal ? ST_ACTIVE : ST_ABORT;
                    w_wait_nx  = w_legal ? WAIT_LOAD : 3'd0;
                end
            end
            ST_ACTIVE: begin
                if (w_exit) begin
                    w_state_nx = ST_IDLE;
                    w_wait_nx  = 3'd0;
                end else if (w_beat) begin
                    w_wait_nx = WAIT_LOAD;
                    if (r_ptr == PTR_LAST) begin
                        w_state_nx = ST_TERM;
                    end
                end else if (r_wait != 3'd0) begin
                    w_wait_nx = r_wait - 3'd1;
                end
            end
            default: begin
                if (w_exit) begin
                    w_state_nx = ST_IDLE;
                    w_wait_nx  = 3'd0;
                end
            end
        endcase
    end

    // Strobes are registered from the next-state view so they change exactly with the FSM.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_dir      <= 1'b0;
            r_wait     <= 3'd0;
            r_ready    <= 1'b0;
            r_term     <= 1'b0;
            r_abort    <= 1'b0;
            r_xfer_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nx;
            r_wait  <= w_wait_nx;
            r_ready <= (w_state_nx == ST_ACTIVE) && (w_wait_nx == 3'd0);
            r_term  <= (w_state_nx == ST_TERM);
            r_abort <= (w_state_nx == ST_ABORT);
            if (r_state == ST_IDLE && w_claim) begin
                r_ptr <= addr[AW+1:2];
                r_dir <= s_wrdn;
            end else if (w_beat && r_ptr != PTR_LAST) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_beat && r_xfer_cnt != 16'hFFFF) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
        end
    end

    // NOTE: the memory must come out of reset seeded, so it is a flop array with async reset rather than a RAM macro.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DW'(INIT_WORD) + DW'(i);
            end
        end else if (w_beat && r_dir) begin
            for (int b = 0; b < NB; b++) begin
                if (!s_cbe[b]) begin
                    r_mem[r_ptr][b*8 +: 8] <= adio_out[b*8 +: 8];
                end
            end
        end
    end

    assign w_drive  = (r_state == ST_ACTIVE) && !r_dir && s_data;
    assign adio_in  = w_drive ? r_mem[r_ptr] : {DW{1'bz}};
    assign s_ready  = r_ready;
    assign s_term   = r_term;
    assign s_abort  = r_abort;
    assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_pci_mem_target_n.sv
// Randomized bench for pci_mem_target_n: a word-array/beat-count reference model
// predicts read data, strobes and xfer_cnt; a second instance checks wait-state timing.
module tb_pci_mem_target_n;

    localparam int          DW    = 32;
    localparam int          DEPTH = 256;
    localparam int          AW    = $clog2(DEPTH);
    localparam int          BAR   = 2;
    localparam int          WS2   = 2;
    localparam logic [31:0] INIT  = 32'h0123_4567;

    logic        CLK = 1'b0;
    logic        reset;
    logic        s_wrdn;
    logic [15:0] pci_cmd;
    logic [31:0] addr;
    logic [7:0]  base_hit;
    logic        addr_vld;
    logic        s_data;
    logic        s_data_vld;
    logic [3:0]  s_cbe;
    logic [31:0] adio_out;

    logic [31:0] adio_in,  ws_adio_in;
    logic        s_ready,  ws_s_ready;
    logic        s_term,   ws_s_term;
    logic        s_abort,  ws_s_abort;
    logic [15:0] xfer_cnt, ws_xfer_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];
    int          m_cnt;

    always #5 CLK = ~CLK;

    pci_mem_target_n #(.DW(DW), .DEPTH(DEPTH), .BAR_IDX(BAR), .WAIT_STATES(0), .INIT_WORD(INIT)) u_dut (
        .CLK(CLK), .reset(reset), .s_wrdn(s_wrdn), .pci_cmd(pci_cmd), .addr(addr),
        .base_hit(base_hit), .addr_vld(addr_vld), .s_data(s_data), .s_data_vld(s_data_vld),
        .s_cbe(s_cbe), .adio_out(adio_out), .adio_in(adio_in), .s_ready(s_ready),
        .s_term(s_term), .s_abort(s_abort), .xfer_cnt(xfer_cnt)
    );

    pci_mem_target_n #(.DW(DW), .DEPTH(DEPTH), .BAR_IDX(BAR), .WAIT_STATES(WS2), .INIT_WORD(INIT)) u_dut_ws (
        .CLK(CLK), .reset(reset), .s_wrdn(s_wrdn), .pci_cmd(pci_cmd), .addr(addr),
        .base_hit(base_hit), .addr_vld(addr_vld), .s_data(s_data), .s_data_vld(s_data_vld),
        .s_cbe(s_cbe), .adio_out(adio_out), .adio_in(ws_adio_in), .s_ready(ws_s_ready),
        .s_term(ws_s_term), .s_abort(ws_s_abort), .xfer_cnt(ws_xfer_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic init_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT + 32'(i);
        m_cnt = 0;
    endtask

    task automatic idle_inputs();
        s_wrdn = 0; pci_cmd = 0; addr = 0; base_hit = 0; addr_vld = 0;
        s_data = 0; s_data_vld = 0; s_cbe = 4'hF; adio_out = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_term",  32'(s_term),  32'd0);
        check("rst_abort", 32'(s_abort), 32'd0);
        check("rst_cnt",   32'(xfer_cnt), 32'd0);
        tick();
        tick();
        #2 reset = 1'b0;
        init_model();
    endtask

    // One complete transaction: address phase, nb data cycles, then s_data drop back to idle.
    task automatic burst(input bit wr, input logic [31:0] a, input logic [15:0] cmd, input int nb,
                         input bit stall, input bit fix, input logic [3:0] fcbe, input logic [31:0] fdata,
                         output logic [31:0] first_rd);
        bit          legal, term, got_first, vld;
        int          mp, done;
        logic [3:0]  cbe;
        logic [31:0] dat;
        legal = (!wr && cmd == 16'h0040) || (wr && cmd == 16'h0080);
        first_rd = '0;
        got_first = 0;
        s_wrdn = wr; pci_cmd = cmd; addr = a; addr_vld = 1;
        base_hit = 8'($urandom) | 8'(1 << BAR);
        s_data = 0; s_data_vld = 0;
        tick();
        addr_vld = 0; base_hit = 0; s_data = 1;
        mp = int'(a[AW+1:2]); term = 0; done = 0;
        while (done < nb) begin
            vld = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            cbe = fix ? fcbe : 4'($urandom);
            dat = fix ? fdata : $urandom;
            s_data_vld = vld; s_cbe = cbe; adio_out = dat;
            #1;
            check("cnt", 32'(xfer_cnt), 32'(m_cnt));
            if (!legal) begin
                check("abort", 32'(s_abort), 32'd1);
                check("abort_rdy", 32'(s_ready), 32'd0);
            end else begin
                check("ready", 32'(s_ready), 32'(!term));
                check("term", 32'(s_term), 32'(term));
                if (!wr && !term) begin
                    check("rdata", adio_in, model_mem[mp]);
                    if (!got_first) begin
                        first_rd = adio_in;
                        got_first = 1;
                    end
                end
                if (vld && !term) begin
                    if (wr)
                        for (int b = 0; b < 4; b++)
                            if (!cbe[b]) model_mem[mp][b*8 +: 8] = dat[b*8 +: 8];
                    if (m_cnt < 65535) m_cnt++;
                    if (mp == DEPTH - 1) term = 1;
                    else mp++;
                end
            end
            if (vld) done++;
            tick();
        end
        s_data = 0; s_data_vld = 0;
        #1;
        check("cnt_end", 32'(xfer_cnt), 32'(m_cnt));
        if (legal) check("term_end", 32'(s_term), 32'(term));
        tick();
        check("idle_ready", 32'(s_ready), 32'd0);
        check("idle_term",  32'(s_term),  32'd0);
        check("idle_abort", 32'(s_abort), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [15:0] cmd;
        int          idx;
        bit          wr;

        reset = 1'b1;
        idle_inputs();
        init_model();
        #1;
        check("por_ready", 32'(s_ready), 32'd0);
        check("por_cnt",   32'(xfer_cnt), 32'd0);
        do_reset();

        // Wait-state instance: s_data_vld held high, ready only every (WS2+1)th cycle.
        s_wrdn = 0; pci_cmd = 16'h0040; addr = 0; addr_vld = 1; base_hit = 8'(1 << BAR);
        tick();
        addr_vld = 0; base_hit = 0; s_data = 1; s_data_vld = 1;
        for (int i = 0; i < 2 * (WS2 + 1); i++) begin
            #1;
            check("ws_ready", 32'(ws_s_ready), 32'((i % (WS2 + 1)) == WS2));
            check("ws_rdata", ws_adio_in, INIT + 32'(i / (WS2 + 1)));
            tick();
        end
        s_data = 0; s_data_vld = 0;
        tick();
        check("ws_cnt", 32'(ws_xfer_cnt), 32'd2);
        do_reset();

        // Reset-seeded read burst.
        burst(0, 32'h0, 16'h0040, 3, 0, 0, 4'h0, 32'h0, rd);
        check("rd0_first", rd, 32'h0123_4567);
        check("rd0_cnt", 32'(xfer_cnt), 32'd3);

        // Byte-lane write then readback.
        burst(1, 32'h8, 16'h0080, 1, 0, 1, 4'b1010, 32'hAABB_CCDD, rd);
        burst(0, 32'h8, 16'h0040, 1, 0, 0, 4'h0, 32'h0, rd);
        check("lane_rd", rd, 32'h01BB_45DD);

        // Illegal claims: direction mismatch and non-memory command.
        burst(1, 32'h10, 16'h0040, 2, 0, 0, 4'h0, 32'h0, rd);
        burst(0, 32'h14, 16'h0004, 2, 0, 0, 4'h0, 32'h0, rd);
        burst(0, 32'h10, 16'h0040, 2, 0, 0, 4'h0, 32'h0, rd);

        // Address phase without our BAR bit is not claimed.
        s_wrdn = 0; pci_cmd = 16'h0040; addr = 32'h20; addr_vld = 1; base_hit = 8'hFF & ~8'(1 << BAR);
        tick();
        addr_vld = 0; base_hit = 0; s_data = 1; s_data_vld = 1;
        #1;
        check("nohit_ready", 32'(s_ready), 32'd0);
        check("nohit_abort", 32'(s_abort), 32'd0);
        tick();
        s_data = 0; s_data_vld = 0;
        tick();
        check("nohit_cnt", 32'(xfer_cnt), 32'(m_cnt));

        // Top word: second beat must be refused with a disconnect.
        burst(1, 32'((DEPTH - 1) * 4), 16'h0080, 2, 0, 0, 4'h0, 32'h0, rd);
        burst(0, 32'((DEPTH - 2) * 4), 16'h0040, 2, 0, 0, 4'h0, 32'h0, rd);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            wr  = 1'($urandom);
            idx = $urandom_range(0, DEPTH - 1);
            a   = ($urandom & 32'hFFFF_FC00) | 32'(idx << 2) | ($urandom & 32'h3);
            cmd = wr ? 16'h0080 : 16'h0040;
            if ($urandom_range(0, 7) == 0) cmd = 16'(1 << $urandom_range(0, 15));
            burst(wr, a, cmd, $urandom_range(1, 6), 1, 0, 4'h0, 32'h0, rd);
        end

        // Reset in the middle of a write burst.
        s_wrdn = 1; pci_cmd = 16'h0080; addr = 32'h40; addr_vld = 1; base_hit = 8'(1 << BAR);
        tick();
        addr_vld = 0; base_hit = 0; s_data = 1;
        for (int i = 0; i < 2; i++) begin
            s_data_vld = 1; s_cbe = 4'h0; adio_out = $urandom;
            tick();
        end
        adio_out = $urandom;
        #2 reset = 1'b1;
        #1;
        check("mid_ready", 32'(s_ready), 32'd0);
        check("mid_term",  32'(s_term),  32'd0);
        check("mid_cnt",   32'(xfer_cnt), 32'd0);
        tick();
        tick();
        #2 reset = 1'b0;
        idle_inputs();
        init_model();
        burst(0, 32'h40, 16'h0040, 2, 0, 0, 4'h0, 32'h0, rd);
        check("mid_rd", rd, INIT + 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
